// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller slice.
//   state_t     : controller states (IDLE / WR / RD / DRAIN), fixed 2-bit encoding
//   DEF_*       : default geometry matching the single-port synchronous RAM
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int unsigned DEF_BITS    = 32;
    localparam int unsigned DEF_ADDR    = 9;
    localparam int unsigned DEF_RAMSIZE = 512;
    localparam int unsigned DEF_LENW    = 4;

endpackage

// File: rtl/mem_access_ctrl_addr_counter.sv
// Burst address generator and remaining-word counter.
//   clk        in   clock, posedge
//   clr        in   synchronous active-high reset (addr=0, cnt=0)
//   load       in   capture load_addr / load_len (start of burst)
//   adv        in   one word done: advance addr (wrap at RAMSIZE-1), decrement cnt
//   load_addr  in   burst start address
//   load_len   in   burst length minus one
//   addr       out  current word address
//   cnt        out  words remaining after the current one
//   last       out  current word is the final one of the burst (cnt==0)
module mem_access_ctrl_addr_counter
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR    = DEF_ADDR,
    parameter int unsigned RAMSIZE = DEF_RAMSIZE,
    parameter int unsigned LENW    = DEF_LENW
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic            adv,
    input  logic [ADDR-1:0] load_addr,
    input  logic [LENW-1:0] load_len,
    output logic [ADDR-1:0] addr,
    output logic [LENW-1:0] cnt,
    output logic            last
);

    always_ff @(posedge clk) begin
        if (clr) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= load_addr;
            cnt  <= load_len;
        end else if (adv) begin
            // RAMSIZE need not be a power of two, so wrap explicitly.
            addr <= (addr == ADDR'(RAMSIZE - 1)) ? '0 : addr + ADDR'(1);
            cnt  <= cnt - LENW'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus-side initiator for the single-port synchronous RAM. Converts single or
// burst requests (req_len+1 words at consecutive, wrapping addresses) into RAM
// read/write strobes. Reads issue one word per cycle; writes are paced by
// wr_valid. done pulses once per completed burst.
//   clk, clr                       clock / synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_addr, req_len   burst type, start address, words minus one
//   wr_data/wr_valid/wr_ready      write data stream
//   rd_data/rd_valid               read data stream, no backpressure
//   done                           one-cycle burst-complete pulse
//   ram_read, ram_write            RAM strobes (never both high)
//   ram_address, ram_dataIn        RAM address / write data
//   ram_dataOut                    RAM read data, valid the cycle after ram_read
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned BITS    = DEF_BITS,
    parameter int unsigned ADDR    = DEF_ADDR,
    parameter int unsigned RAMSIZE = DEF_RAMSIZE,
    parameter int unsigned LENW    = DEF_LENW
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [ADDR-1:0] req_addr,
    input  logic [LENW-1:0] req_len,
    input  logic [BITS-1:0] wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [BITS-1:0] rd_data,
    output logic            rd_valid,
    output logic            done,
    output logic            ram_read,
    output logic            ram_write,
    output logic [ADDR-1:0] ram_address,
    output logic [BITS-1:0] ram_dataIn,
    input  logic [BITS-1:0] ram_dataOut
);

    state_t          state, state_next;
    logic [ADDR-1:0] addr;
    logic [LENW-1:0] cnt;
    logic            last;
    logic            load;
    logic            adv;

    assign load = (state == ST_IDLE) && req_valid;
    assign adv  = (state == ST_RD) || ((state == ST_WR) && wr_valid);

    mem_access_ctrl_addr_counter #(
        .ADDR    (ADDR),
        .RAMSIZE (RAMSIZE),
        .LENW    (LENW)
    ) u_cnt (
        .clk       (clk),
        .clr       (clr),
        .load      (load),
        .adv       (adv),
        .load_addr (req_addr),
        .load_len  (req_len),
        .addr      (addr),
        .cnt       (cnt),
        .last      (last)
    );

    // State register; rd_valid marks "a read was issued last cycle", so a
    // reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            rd_valid <= (state == ST_RD);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid) state_next = req_write ? ST_WR : ST_RD;
            ST_WR:    if (wr_valid && last) state_next = ST_DRAIN;
            ST_RD:    if (last) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        ram_address = '0;
        ram_dataIn  = '0;
        done        = 1'b0;
        rd_data     = ram_dataOut;
        case (state)
            ST_IDLE:  req_ready = 1'b1;
            ST_WR: begin
                wr_ready    = 1'b1;
                ram_write   = wr_valid;
                ram_address = addr;
                ram_dataIn  = wr_data;
            end
            ST_RD: begin
                ram_read    = 1'b1;
                ram_address = addr;
            end
            ST_DRAIN: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural synchronous RAM.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        ram_read;
    logic        ram_write;
    logic [8:0]  ram_address;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] ram     [512];
    logic [31:0] ref_mem [512];
    logic [31:0] wbuf    [16];

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .BITS    (32),
        .ADDR    (9),
        .RAMSIZE (512),
        .LENW    (4)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_dataIn  (ram_dataIn),
        .ram_dataOut (ram_dataOut)
    );

    // Single-port synchronous RAM
    always @(posedge clk) begin
        if (ram_write) ram[ram_address] <= ram_dataIn;
        if (ram_read)  ram_dataOut <= ram[ram_address];
    end

    // Strobe exclusivity, checked every cycle of every test
    always @(negedge clk) begin
        compared++;
        assert ((ram_read && ram_write) === 1'b0) else begin
            mismatched++;
            $error("FAIL strobe_excl: observed read=%b write=%b required not both 1", ram_read, ram_write);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap(input int a);
        return a % 512;
    endfunction

    // Write burst of len+1 words from wbuf; stall_mask bit i inserts a
    // wr_valid=0 cycle before word i. hold leaves req_valid asserted.
    task automatic do_write(input int a, input int len, input int stall_mask, input bit hold);
        chk("wr_req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = 1; req_addr = a[8:0]; req_len = len[3:0];
        step();
        if (!hold) req_valid = 0;
        for (int i = 0; i <= len; i++) begin
            if (stall_mask[i]) begin
                wr_valid = 0; #1;
                chk("wr_stall_ready", wr_ready, 1);
                chk("wr_stall_nowrite", ram_write, 0);
                chk("wr_stall_done", done, 0);
                step();
            end
            wr_valid = 1; wr_data = wbuf[i]; #1;
            chk("wr_ready", wr_ready, 1);
            chk("wr_strobe", ram_write, 1);
            chk("wr_noread", ram_read, 0);
            chk("wr_addr", ram_address, wrap(a + i));
            chk("wr_data", ram_dataIn, wbuf[i]);
            chk("wr_busy_req_ready", req_ready, 0);
            chk("wr_done_early", done, 0);
            ref_mem[wrap(a + i)] = wbuf[i];
            step();
        end
        wr_valid = 0; #1;
        chk("wr_done", done, 1);
        chk("wr_drain_nowrite", ram_write, 0);
        chk("wr_drain_wr_ready", wr_ready, 0);
        step();
        chk("wr_done_pulse", done, 0);
        chk("wr_back_idle", req_ready, 1);
    endtask

    // Read burst of len+1 words, each checked against the reference memory.
    task automatic do_read(input int a, input int len, input bit hold);
        chk("rd_req_ready_idle", req_ready, 1);
        req_valid = 1; req_write = 0; req_addr = a[8:0]; req_len = len[3:0];
        step();
        if (!hold) req_valid = 0;
        for (int i = 0; i <= len; i++) begin
            chk("rd_strobe", ram_read, 1);
            chk("rd_nowrite", ram_write, 0);
            chk("rd_addr", ram_address, wrap(a + i));
            chk("rd_valid_lat", rd_valid, (i > 0) ? 1 : 0);
            if (i > 0) chk("rd_data", rd_data, ref_mem[wrap(a + i - 1)]);
            chk("rd_busy_req_ready", req_ready, 0);
            chk("rd_done_early", done, 0);
            step();
        end
        chk("rd_final_valid", rd_valid, 1);
        chk("rd_final_data", rd_data, ref_mem[wrap(a + len)]);
        chk("rd_done", done, 1);
        chk("rd_drain_noread", ram_read, 0);
        step();
        chk("rd_valid_end", rd_valid, 0);
        chk("rd_done_pulse", done, 0);
        chk("rd_back_idle", req_ready, 1);
    endtask

    initial begin
        clr = 1; req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 0;
        step();
        step();
        clr = 0; #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_ram_read", ram_read, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_address", ram_address, 0);

        // Fill the whole RAM so every later read has a known expectation
        for (int b = 0; b < 32; b++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            do_write(b * 16, 15, 0, 0);
        end

        // Single write then single read
        wbuf[0] = 32'hDEADBEEF;
        do_write(9'h010, 0, 0, 0);
        do_read(9'h010, 0, 0);

        // Read burst of 4 from preloaded 1..4
        for (int k = 0; k < 4; k++) wbuf[k] = k + 1;
        do_write(9'h020, 3, 0, 0);
        do_read(9'h020, 3, 0);

        // Wrapping write burst with a wait state before the 2nd word
        for (int k = 0; k < 4; k++) wbuf[k] = 32'hA5A50000 + k;
        do_write(9'h1FE, 3, 32'h2, 0);
        do_read(9'h1FE, 3, 0);

        // Reset mid read burst after two words
        req_valid = 1; req_write = 0; req_addr = 9'h040; req_len = 4'd7;
        step();
        req_valid = 0;
        step();
        step();
        clr = 1;
        step();
        clr = 0; #1;
        chk("clr_req_ready", req_ready, 1);
        chk("clr_ram_read", ram_read, 0);
        chk("clr_rd_valid", rd_valid, 0);
        chk("clr_done", done, 0);
        chk("clr_address", ram_address, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("clr_no_rd_valid", rd_valid, 0);
            chk("clr_no_done", done, 0);
            chk("clr_idle", req_ready, 1);
        end
        do_read(9'h040, 2, 0);

        // req_valid held high across busy bursts: back-to-back requests
        for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
        do_read(9'h1FD, 5, 1);
        do_write(9'h100, 2, 32'h4, 1);
        do_read(9'h100, 2, 0);

        // Randomized bursts
        for (int r = 0; r < 12; r++) begin
            int a, len;
            a   = $urandom_range(0, 511);
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
                do_write(a, len, int'($urandom & 32'hFFFF) & int'($urandom & 32'hFFFF), 0);
            end else begin
                do_read(a, len, 0);
            end
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
